// File: rtl/adder_seq_32.sv
// Two-requester 32-bit add/sub unit built on a shared external 16-bit adder.
// The low half runs first, then the high half; a response slot follows.
module adder_seq_32 #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_ovf,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_sum,
  input  logic        add_cout,
  input  logic        add_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    RESP
  } state_t;

  state_t      state;
  logic        ptr;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;
  logic        op_id;
  logic        carry;
  logic [15:0] sum_lo;

  logic        g0;
  logic        g1;
  logic        in_idle;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        sel_sub;

  // Round-robin: a lone requester wins, a tie goes to the pointer holder.
  always_comb begin
    g0 = req0_valid && (!req1_valid || !ptr);
    g1 = req1_valid && (!req0_valid || ptr);
  end

  assign in_idle    = (state == IDLE) && rst_n;
  assign req0_ready = in_idle && g0;
  assign req1_ready = in_idle && g1;

  always_comb begin
    sel_a   = 32'h0;
    sel_b   = 32'h0;
    sel_sub = 1'b0;
    unique case (1'b1)
      g1: begin
        sel_a   = req1_a;
        sel_b   = req1_b;
        sel_sub = req1_sub;
      end
      g0: begin
        sel_a   = req0_a;
        sel_b   = req0_b;
        sel_sub = req0_sub;
      end
      default: ;
    endcase
  end

  always_comb begin
    add_a   = 16'h0;
    add_b   = 16'h0;
    add_cin = 1'b0;
    unique case (state)
      LO: begin
        add_a   = op_a[15:0];
        add_b   = op_b[15:0];
        add_cin = op_sub;
      end
      HI: begin
        add_a   = op_a[31:16];
        add_b   = op_b[31:16];
        add_cin = carry;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= RR_INIT;
      op_a      <= 32'h0;
      op_b      <= 32'h0;
      op_sub    <= 1'b0;
      op_id     <= 1'b0;
      carry     <= 1'b0;
      sum_lo    <= 16'h0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= 32'h0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (g0 || g1) begin
            op_a   <= sel_a;
            op_b   <= sel_sub ? ~sel_b : sel_b;
            op_sub <= sel_sub;
            op_id  <= g1;
            ptr    <= g0;
            state  <= LO;
          end
        end
        LO: begin
          sum_lo <= add_sum;
          carry  <= add_cout;
          state  <= HI;
        end
        HI: begin
          rsp_sum   <= {add_sum, sum_lo};
          rsp_cout  <= add_cout;
          rsp_ovf   <= add_ovf;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_32.sv
// Self-checking bench for adder_seq_32: scoreboard model plus literal vectors.
// Also models the external 16-bit adder the DUT drives.
module tb_adder_seq_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        req0_sub = 0, req1_sub = 0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic        rsp_id, rsp_cout, rsp_ovf;
  logic [31:0] rsp_sum;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout, add_ovf;

  always #5 clk = ~clk;

  adder_seq_32 #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .add_ovf(add_ovf)
  );

  // External 16-bit adder slice
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};
  assign add_ovf = (add_a[15] == add_b[15]) && (add_sum[15] != add_a[15]);

  int total = 0;
  int passed = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
  endtask

  typedef struct {
    logic        id;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acyc;
  } exp_t;

  exp_t q[$];
  int   gid_q[$];
  int   gcyc_q[$];
  logic prev_v = 0, prev_stall = 0;
  logic [34:0] prev_data = '0;

  function automatic exp_t model(input logic id, input logic [31:0] a,
                                 input logic [31:0] b, input logic sub,
                                 input int c);
    exp_t e;
    logic [32:0] w;
    e.id = id;
    e.acyc = c;
    if (sub) begin
      e.sum  = a - b;
      e.cout = (a >= b);
      e.ovf  = (a[31] != b[31]) && (e.sum[31] != a[31]);
    end else begin
      w      = {1'b0, a} + {1'b0, b};
      e.sum  = w[31:0];
      e.cout = w[32];
      e.ovf  = (a[31] == b[31]) && (e.sum[31] != a[31]);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q.delete();
      prev_v = 0;
      prev_stall = 0;
    end else begin
      if (req0_ready && req1_ready) chk("both_ready", 1, 0);
      if (req0_ready && req0_valid) begin
        q.push_back(model(1'b0, req0_a, req0_b, req0_sub, cyc));
        gid_q.push_back(0);
        gcyc_q.push_back(cyc);
      end
      if (req1_ready && req1_valid) begin
        q.push_back(model(1'b1, req1_a, req1_b, req1_sub, cyc));
        gid_q.push_back(1);
        gcyc_q.push_back(cyc);
      end
      if (prev_stall) begin
        chk("stall_valid", rsp_valid, 1);
        chk("stall_data", {rsp_id, rsp_cout, rsp_ovf, rsp_sum}, prev_data);
      end
      if (rsp_valid) begin
        if (q.size() == 0) chk("spurious_rsp", 1, 0);
        else begin
          if (!prev_v) chk("latency", cyc - q[0].acyc, 3);
          if (rsp_ready) begin
            e = q.pop_front();
            chk("m_id", rsp_id, e.id);
            chk("m_sum", rsp_sum, e.sum);
            chk("m_cout", rsp_cout, e.cout);
            chk("m_ovf", rsp_ovf, e.ovf);
          end
        end
      end
      prev_v = rsp_valid;
      prev_stall = rsp_valid && !rsp_ready;
      prev_data = {rsp_id, rsp_cout, rsp_ovf, rsp_sum};
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_r0"}, req0_ready, 0);
    chk({tag, "_r1"}, req1_ready, 0);
    chk({tag, "_rv"}, rsp_valid, 0);
    chk({tag, "_rsp"}, {rsp_id, rsp_cout, rsp_ovf, rsp_sum}, 0);
    chk({tag, "_add"}, {add_a, add_b, add_cin}, 0);
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !rsp_valid) break;
    end
    if (n == 50) chk("drain_timeout", 0, 1);
  endtask

  task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] es,
                        input logic ec, input logic eo);
    int n;
    logic r;
    @(posedge clk); #1;
    if (id) begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_sub = sub;
    end else begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_sub = sub;
    end
    r = 0;
    for (n = 0; n < 20 && !r; n++) begin
      @(negedge clk);
      r = id ? req1_ready : req0_ready;
    end
    if (!r) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    req0_a = $urandom; req0_b = $urandom; req0_sub = ~req0_sub;
    req1_a = $urandom; req1_b = $urandom; req1_sub = ~req1_sub;
    r = 0;
    for (n = 0; n < 20 && !r; n++) begin
      @(negedge clk);
      r = rsp_valid && rsp_ready;
    end
    if (!r) chk("rsp_timeout", 0, 1);
    chk("lit_id", rsp_id, id);
    chk("lit_sum", rsp_sum, es);
    chk("lit_cout", rsp_cout, ec);
    chk("lit_ovf", rsp_ovf, eo);
  endtask

  initial begin
    int n;
    rst_n = 0;
    req0_valid = 1; req1_valid = 1;
    #12;
    chk_zero("rst");
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    rst_n = 1;

    run_op(0, 32'h0000FFFF, 32'h00000001, 0, 32'h00010000, 0, 0);
    run_op(1, 32'd5, 32'd7, 1, 32'hFFFFFFFE, 0, 0);
    run_op(1, 32'd7, 32'd5, 1, 32'h00000002, 1, 0);
    run_op(0, 32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 0, 1);
    run_op(0, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1, 0);
    run_op(1, 32'h12345678, 32'h9ABCDEF0, 0, 32'hACF13568, 0, 0);
    run_op(0, 32'h80000000, 32'h00000001, 1, 32'h7FFFFFFF, 1, 1);
    drain();

    // Round-robin with both requesters held valid
    @(posedge clk); #1 rst_n = 0;
    #3 rst_n = 1;
    gid_q.delete(); gcyc_q.delete();
    @(posedge clk); #1;
    rsp_ready = 1;
    req0_valid = 1; req0_a = 32'h100; req0_b = 32'h23; req0_sub = 0;
    req1_valid = 1; req1_a = 32'h50; req1_b = 32'h60; req1_sub = 1;
    for (n = 0; n < 40 && gid_q.size() < 4; n++) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    if (gid_q.size() < 4) chk("rr_timeout", gid_q.size(), 4);
    else begin
      chk("rr_g0", gid_q[0], 0);
      chk("rr_g1", gid_q[1], 1);
      chk("rr_g2", gid_q[2], 0);
      chk("rr_g3", gid_q[3], 1);
      for (int i = 1; i < 4; i++) chk("rr_gap", gcyc_q[i] - gcyc_q[i-1], 4);
    end
    drain();

    // Response stall for five cycles
    @(posedge clk); #1;
    rsp_ready = 0;
    req0_valid = 1; req0_a = 32'h10; req0_b = 32'h20; req0_sub = 0;
    for (n = 0; n < 20 && !req0_ready; n++) @(negedge clk);
    @(posedge clk); #1;
    req0_a = 32'h3; req0_b = 32'h4;
    req1_valid = 1; req1_a = 32'd100; req1_b = 32'd1; req1_sub = 1;
    for (n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_rdy", {req0_ready, req1_ready}, 0);
      chk("stall_rv", rsp_valid, 1);
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(negedge clk);
    chk("hs_rdy", {req0_ready, req1_ready}, 0);
    chk("hs_rv", rsp_valid, 1);
    @(negedge clk);
    chk("resume_r1", req1_ready, 1);
    chk("resume_r0", req0_ready, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    drain();

    // Reset while the high half is in flight
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 32'h12345678; req0_b = 32'h11111111; req0_sub = 0;
    for (n = 0; n < 20 && !req0_ready; n++) @(negedge clk);
    @(posedge clk); #1 req0_valid = 0;
    @(posedge clk); #2;
    chk("hi_add_busy", add_a, 16'h1234);
    rst_n = 0;
    req0_valid = 1; req1_valid = 1;
    req1_a = 32'h7; req1_b = 32'h9; req1_sub = 0;
    #1 chk_zero("midrst");
    @(posedge clk); #3 rst_n = 1;
    @(negedge clk);
    chk("post_rst_r0", req0_ready, 1);
    chk("post_rst_r1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
